rst_seq_gen: RTL and testbench

RST_SEQ_GEN -- requirements
Module: rst_seq_gen

---
 rtl/rst_seq_gen.sv | 123 ++++++++++++
 tb/tb_rst_seq_gen.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/rst_seq_gen.sv
// Reset/clear sequencer: releases rst_n_out, then clear_n_out after a gap,
// and services soft-clear requests with a 4-phase req/ack handshake.
module rst_seq_gen #(
  parameter int RST_HOLD = 16,
  parameter int GAP      = 4,
  parameter int CLR_HOLD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_req,
  output logic clr_ack,
  output logic rst_n_out,
  output logic clear_n_out,
  output logic busy
);

  localparam logic [2:0] S_HOLD = 3'd0;
  localparam logic [2:0] S_GAP  = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_CLR  = 3'd3;
  localparam logic [2:0] S_ACK  = 3'd4;

  localparam logic [7:0] RST_HOLD_C = 8'(RST_HOLD);
  localparam logic [7:0] GAP_C      = 8'(GAP);
  localparam logic [7:0] CLR_HOLD_C = 8'(CLR_HOLD);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rst_n_q, rst_n_d;
  logic       clear_n_q, clear_n_d;
  logic       ack_q, ack_d;
  logic       busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rst_n_d   = rst_n_q;
    clear_n_d = clear_n_q;
    ack_d     = ack_q;
    busy_d    = busy_q;
    case (state_q)
      S_HOLD: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = S_GAP;
          rst_n_d = 1'b1;
          cnt_d   = GAP_C;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d   = S_RUN;
          clear_n_d = 1'b1;
          busy_d    = 1'b0;
        end
      end
      S_RUN: begin
        if (clr_req) begin
          state_d   = S_CLR;
          clear_n_d = 1'b0;
          busy_d    = 1'b1;
          cnt_d     = CLR_HOLD_C;
        end
      end
      S_CLR: begin
        // clr_req is deliberately not looked at: the clear pulse always runs to length
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d   = S_ACK;
          clear_n_d = 1'b1;
          ack_d     = 1'b1;
        end
      end
      S_ACK: begin
        if (!clr_req) begin
          state_d = S_RUN;
          ack_d   = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d   = S_HOLD;
        cnt_d     = RST_HOLD_C;
        rst_n_d   = 1'b0;
        clear_n_d = 1'b0;
        ack_d     = 1'b0;
        busy_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_HOLD;
      cnt_q     <= RST_HOLD_C;
      rst_n_q   <= 1'b0;
      clear_n_q <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_n_q   <= rst_n_d;
      clear_n_q <= clear_n_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  assign clr_ack     = ack_q;
  assign rst_n_out   = rst_n_q;
  assign clear_n_out = clear_n_q;
  assign busy        = busy_q;

  // Ordering and status invariants checked every cycle
  a_clear_under_reset: assert property (@(posedge clk) !(clear_n_q && !rst_n_q));
  a_no_joint_rise: assert property (@(posedge clk) disable iff (rst)
    !($rose(rst_n_q) && $rose(clear_n_q)));
  a_busy_state: assert property (@(posedge clk) disable iff (rst)
    busy_q == (state_q != S_RUN));

endmodule

// File: tb/tb_rst_seq_gen.sv
// Randomised scoreboard bench for rst_seq_gen: default and minimum-parameter
// instances share stimulus and are checked against a timestamp-based model.
module tb_rst_seq_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_req = 1'b0;

  logic ack_a, rn_a, cn_a, busy_a;
  logic ack_b, rn_b, cn_b, busy_b;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  always #5 clk = ~clk;

  rst_seq_gen u_def (
    .clk(clk), .rst(rst), .clr_req(clr_req),
    .clr_ack(ack_a), .rst_n_out(rn_a), .clear_n_out(cn_a), .busy(busy_a)
  );

  rst_seq_gen #(.RST_HOLD(1), .GAP(1), .CLR_HOLD(1)) u_min (
    .clk(clk), .rst(rst), .clr_req(clr_req),
    .clr_ack(ack_b), .rst_n_out(rn_b), .clear_n_out(cn_b), .busy(busy_b)
  );

  // Model: n counts edges since reset released; a soft clear is a start timestamp.
  typedef struct {
    int r;
    int g;
    int c;
    int n;
    bit act;
    int tc;
  } model_t;

  model_t m_a, m_b;
  logic [3:0] q_a[$];
  logic [3:0] q_b[$];

  function automatic logic [3:0] step(inout model_t s, input logic r_in, input logic req);
    logic rn, cn, ack, bsy;
    int rel;
    rn = 1'b0; cn = 1'b0; ack = 1'b0; bsy = 1'b1;
    if (r_in) begin
      s.n = 0;
      s.act = 1'b0;
    end else begin
      s.n++;
      rel = s.r + s.g;
      rn = (s.n >= s.r);
      if (s.n >= rel) begin
        if (!s.act && s.n > rel && req) begin
          s.act = 1'b1;
          s.tc = s.n;
        end
        if (!s.act) begin
          cn = 1'b1;
          bsy = 1'b0;
        end else if (s.n - s.tc < s.c) begin
          cn = 1'b0;
        end else begin
          cn = 1'b1;
          ack = 1'b1;
          if (s.n - s.tc > s.c && !req) begin
            s.act = 1'b0;
            ack = 1'b0;
            bsy = 1'b0;
          end
        end
      end
    end
    return {rn, cn, ack, bsy};
  endfunction

  task automatic cyc(input logic r_in, input logic req);
    rst = r_in;
    clr_req = req;
    q_a.push_back(step(m_a, r_in, req));
    q_b.push_back(step(m_b, r_in, req));
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic r_in, input logic req);
    for (int i = 0; i < n; i++) cyc(r_in, req);
  endtask

  always @(negedge clk) begin
    logic [3:0] exp_v, act_v;
    cycle++;
    if (q_a.size() > 0) begin
      exp_v = q_a.pop_front();
      act_v = {rn_a, cn_a, ack_a, busy_a};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL def_outputs cycle=%0d {rst_n,clear_n,ack,busy} got=%b want=%b",
                 cycle, act_v, exp_v);
      end
    end
    if (q_b.size() > 0) begin
      exp_v = q_b.pop_front();
      act_v = {rn_b, cn_b, ack_b, busy_b};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL min_outputs cycle=%0d {rst_n,clear_n,ack,busy} got=%b want=%b",
                 cycle, act_v, exp_v);
      end
    end
  end

  initial begin
    int rlen;
    logic req_r;
    m_a = '{r: 16, g: 4, c: 8, n: 0, act: 1'b0, tc: 0};
    m_b = '{r: 1, g: 1, c: 1, n: 0, act: 1'b0, tc: 0};

    // Power-up: reset 3 cycles, then idle through release
    run(3, 1'b1, 1'b0);
    run(25, 1'b0, 1'b0);
    // Soft clear: request for 10 edges then drop
    run(10, 1'b0, 1'b1);
    run(5, 1'b0, 1'b0);
    // Early request held from HOLD edge 5
    run(1, 1'b1, 1'b0);
    run(4, 1'b0, 1'b0);
    run(30, 1'b0, 1'b1);
    run(5, 1'b0, 1'b0);
    // Reset in the middle of a clear, then full release again
    run(3, 1'b0, 1'b1);
    run(1, 1'b1, 1'b1);
    run(25, 1'b0, 1'b0);
    // Back-to-back requests with short gaps
    for (int k = 0; k < 6; k++) begin
      run(12, 1'b0, 1'b1);
      run(k % 3, 1'b0, 1'b0);
    end

    rlen = 0;
    req_r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (rlen == 0 && $urandom_range(0, 399) == 0) rlen = $urandom_range(1, 3);
      if ($urandom_range(0, 7) == 0) req_r = ~req_r;
      cyc(rlen > 0, req_r);
      if (rlen > 0) rlen--;
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
